// File: rtl/capture_pkg.sv
// Shared definitions for the capture trigger sequencer: state encoding,
// trigger slope constants and the default sample width.
package capture_pkg;

  localparam int CAP_DATA_W = 8;

  localparam logic TRIG_RISING  = 1'b0;
  localparam logic TRIG_FALLING = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_EMPTY = 3'd1,
    ST_ARMED      = 3'd2,
    ST_CAPTURE    = 3'd3,
    ST_HOLDOFF    = 3'd4
  } state_t;

endpackage

// File: rtl/trigger_detect.sv
// Level/slope trigger with hysteresis: the flag must first see the signal on
// the far side of the saturated threshold before a crossing may fire.
module trigger_detect
  import capture_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int HYST   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_level,
  input  logic              i_slope,
  input  logic              i_clear,
  input  logic              i_force,
  output logic              o_hit
);

  localparam logic [DATA_W:0] HYST_X = (DATA_W + 1)'(HYST);

  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a);
    logic [DATA_W:0] d;
    d = {1'b0, a} - HYST_X;
    return d[DATA_W] ? '0 : d[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a);
    logic [DATA_W:0] s;
    s = {1'b0, a} + HYST_X;
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
  endfunction

  logic              r_flag;
  logic              w_rising;
  logic [DATA_W-1:0] w_lo;
  logic [DATA_W-1:0] w_hi;
  logic              w_arm_cond;
  logic              w_cross;

  assign w_rising   = (i_slope == TRIG_RISING);
  assign w_lo       = sat_sub(i_level);
  assign w_hi       = sat_add(i_level);
  // A saturated bound makes the strict compare unsatisfiable, so no re-arm.
  assign w_arm_cond = w_rising ? (i_sample < w_lo) : (i_sample > w_hi);
  assign w_cross    = w_rising ? (i_sample >= i_level) : (i_sample <= i_level);
  assign o_hit      = i_valid && ((r_flag && w_cross) || i_force);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
    end else if (i_clear) begin
      r_flag <= 1'b0;
    end else if (i_valid && w_arm_cond) begin
      r_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/capture_trigger_ctrl.sv
// Trigger/capture sequencer in front of the sample FIFO.
// Optional auto trigger after AUTO_TIMEOUT armed clocks: define CAPTURE_TRIG_AUTO_EN.
module capture_trigger_ctrl
  import capture_pkg::*;
#(
  parameter int DATA_W       = CAP_DATA_W,
  parameter int HYST         = 4,
  parameter int HOLDOFF      = 64,
  parameter int AUTO_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              single_shot,
  input  logic              arm,
  input  logic              fifo_wrfull,
  input  logic              fifo_wrempty,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_wrreq,
  output logic              triggered,
  output logic              trig_auto,
  output logic [2:0]        state
);

  localparam int             HCW     = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [HCW-1:0] HOLD_M1 = HCW'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic              r_wstrobe;
  logic              w_wstrobe_nxt;
  logic [HCW-1:0]    r_hold_cnt;
  logic              w_hold_done;
  logic              w_hit;
  logic              w_force;

  trigger_detect #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_trigger_detect (
    .clk      (clk),
    .rst_n    (reset),
    .i_sample (sample_in),
    .i_valid  (sample_valid),
    .i_level  (trig_level),
    .i_slope  (trig_slope),
    .i_clear  (r_state != ST_ARMED),
    .i_force  (w_force),
    .o_hit    (w_hit)
  );

`ifdef CAPTURE_TRIG_AUTO_EN
  localparam int            AW        = (AUTO_TIMEOUT < 1) ? 1 : $clog2(AUTO_TIMEOUT + 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_TIMEOUT);

  logic [AW-1:0] r_auto_cnt;
  logic          r_trig_auto;

  assign w_force   = (r_auto_cnt == AUTO_LAST);
  assign trig_auto = r_trig_auto;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_auto_cnt  <= '0;
      r_trig_auto <= 1'b0;
    end else begin
      r_trig_auto <= (r_state == ST_ARMED) && w_force && sample_valid;
      if (r_state != ST_ARMED) begin
        r_auto_cnt <= '0;
      end else if (!w_force) begin
        r_auto_cnt <= r_auto_cnt + AW'(1);
      end
    end
  end
`else
  // Auto trigger compiled out; the parameter stays for a uniform interface.
  assign w_force   = 1'b0 & (AUTO_TIMEOUT == 0);
  assign trig_auto = 1'b0;
`endif

  assign w_hold_done = (HOLDOFF == 0) || (sample_valid && (r_hold_cnt == HOLD_M1));

  always_comb begin
    w_state_nxt   = r_state;
    w_wstrobe_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (arm || !single_shot) w_state_nxt = ST_WAIT_EMPTY;
      end
      ST_WAIT_EMPTY: begin
        if (fifo_wrempty) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_hit) begin
          w_state_nxt   = ST_CAPTURE;
          w_wstrobe_nxt = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (fifo_wrfull) w_state_nxt = ST_HOLDOFF;
        else             w_wstrobe_nxt = sample_valid;
      end
      ST_HOLDOFF: begin
        if (w_hold_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_wstrobe  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wstrobe <= w_wstrobe_nxt;
      if (w_wstrobe_nxt) r_data <= sample_in;
      if (r_state != ST_HOLDOFF) begin
        r_hold_cnt <= '0;
      end else if (sample_valid) begin
        r_hold_cnt <= r_hold_cnt + HCW'(1);
      end
    end
  end

  // The full flag gates the registered strobe so a write never meets a full FIFO.
  assign fifo_wrreq = r_wstrobe & ~fifo_wrfull;
  assign fifo_data  = r_data;
  assign triggered  = (r_state == ST_CAPTURE);
  assign state      = r_state;

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Directed testbench for capture_trigger_ctrl; runs the auto-trigger case
// when CAPTURE_TRIG_AUTO_EN is defined, the no-capture case otherwise.
module tb_capture_trigger_ctrl;
  import capture_pkg::*;

  localparam int DW     = 8;
  localparam int HOLD_N = 8;
  localparam int AUTO_N = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic [DW-1:0] trig_level;
  logic          trig_slope;
  logic          single_shot;
  logic          arm;
  logic          fifo_wrfull;
  logic          fifo_wrempty;
  logic [DW-1:0] fifo_data;
  logic          fifo_wrreq;
  logic          triggered;
  logic          trig_auto;
  logic [2:0]    state;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;

  capture_trigger_ctrl #(
    .DATA_W       (DW),
    .HYST         (4),
    .HOLDOFF      (HOLD_N),
    .AUTO_TIMEOUT (AUTO_N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .single_shot  (single_shot),
    .arm          (arm),
    .fifo_wrfull  (fifo_wrfull),
    .fifo_wrempty (fifo_wrempty),
    .fifo_data    (fifo_data),
    .fifo_wrreq   (fifo_wrreq),
    .triggered    (triggered),
    .trig_auto    (trig_auto),
    .state        (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wrreq) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] s, input logic v);
    sample_in    = s;
    sample_valid = v;
    tick();
  endtask

  task automatic do_reset;
    reset        = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    trig_level   = 8'd128;
    trig_slope   = TRIG_RISING;
    single_shot  = 1'b1;
    arm          = 1'b0;
    fifo_wrfull  = 1'b0;
    fifo_wrempty = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic go_armed(input string tag);
    single_shot = 1'b0;
    tick();
    tick();
    chk(tag, state, ST_ARMED);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int first_v;
    int vcnt;
    int k;
    int armed;
    logic v;
    logic [DW-1:0] noise [5];
    logic [DW-1:0] low [6];

    noise = '{8'd126, 8'd127, 8'd128, 8'd129, 8'd130};
    low   = '{8'd0, 8'd1, 8'd2, 8'd5, 8'd255, 8'd3};

    // Reset values while reset is held
    reset        = 1'b0;
    sample_in    = 8'd77;
    sample_valid = 1'b1;
    trig_level   = 8'd128;
    trig_slope   = TRIG_RISING;
    single_shot  = 1'b0;
    arm          = 1'b1;
    fifo_wrfull  = 1'b0;
    fifo_wrempty = 1'b1;
    #22;
    chk("rst_state", state, ST_IDLE);
    chk("rst_wrreq", fifo_wrreq, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_trig_auto", trig_auto, 0);
    chk("rst_data", fifo_data, 0);

    // Continuous mode, rising ramp through level 128
    do_reset();
    go_armed("ramp_armed");
    first_v = -1;
    for (int i = 100; i < 256; i++) begin
      drive(DW'(i), 1'b1);
      if (fifo_wrreq) begin
        first_v = i;
        break;
      end
      if (triggered) break;
    end
    chk("ramp_trig_sample", first_v, 128);
    chk("ramp_first_word", fifo_data, 128);
    chk("ramp_triggered", triggered, 1);
    drive(8'd129, 1'b1);
    chk("ramp_second_word", fifo_data, 129);
    chk("ramp_second_wrreq", fifo_wrreq, 1);
    sample_in   = 8'd130;
    fifo_wrfull = 1'b1;
    #1;
    chk("full_gates_wrreq", fifo_wrreq, 0);
    chk("full_still_capture", state, ST_CAPTURE);
    tick();
    chk("full_to_holdoff", state, ST_HOLDOFF);
    chk("holdoff_untriggered", triggered, 0);
    fifo_wrfull = 1'b0;
    vcnt = 0;
    k = 0;
    while (state == ST_HOLDOFF && k < 100) begin
      v = ((k % 3) != 2);
      drive(8'd0, v);
      if (v) vcnt++;
      k++;
    end
    chk("holdoff_valid_count", vcnt, HOLD_N);
    chk("holdoff_to_idle", state, ST_IDLE);

    // Single shot: idle without arm, then exactly one frame per arm
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < 1000; i++) drive(DW'($urandom_range(0, 255)), 1'b1);
    chk("ss_no_writes", wr_cnt - base, 0);
    chk("ss_idle", state, ST_IDLE);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("ss_wait_empty", state, ST_WAIT_EMPTY);
    tick();
    chk("ss_armed", state, ST_ARMED);
    drive(8'd100, 1'b1);
    drive(8'd140, 1'b1);
    chk("ss_first_wrreq", fifo_wrreq, 1);
    chk("ss_first_word", fifo_data, 140);
    drive(8'd141, 1'b1);
    drive(8'd142, 1'b1);
    drive(8'd143, 1'b1);
    fifo_wrfull  = 1'b1;
    fifo_wrempty = 1'b0;
    drive(8'd144, 1'b1);
    chk("ss_holdoff", state, ST_HOLDOFF);
    for (int i = 0; i < 30; i++) drive(8'd10, 1'b1);
    chk("ss_back_idle", state, ST_IDLE);
    chk("ss_frame_words", wr_cnt - base, 3);
    fifo_wrfull  = 1'b0;
    fifo_wrempty = 1'b1;

    // Noise around the level without a hysteresis excursion
    do_reset();
    go_armed("noise_armed");
    base = wr_cnt;
    for (int r = 0; r < 15; r++)
      for (int j = 0; j < 5; j++) drive(noise[j], 1'b1);
    chk("noise_no_writes", wr_cnt - base, 0);
    chk("noise_still_armed", state, ST_ARMED);
    drive(8'd120, 1'b1);
    chk("noise_dip_no_wrreq", fifo_wrreq, 0);
    drive(8'd128, 1'b1);
    chk("noise_trig_wrreq", fifo_wrreq, 1);
    chk("noise_trig_word", fifo_data, 128);

    // Falling slope, then asynchronous reset mid-capture
    do_reset();
    trig_slope = TRIG_FALLING;
    trig_level = 8'd200;
    go_armed("fall_armed");
    drive(8'd190, 1'b1);
    chk("fall_no_flag", fifo_wrreq, 0);
    drive(8'd255, 1'b1);
    chk("fall_flag_only", fifo_wrreq, 0);
    drive(8'd190, 1'b1);
    chk("fall_wrreq", fifo_wrreq, 1);
    chk("fall_word", fifo_data, 190);
    chk("fall_triggered", triggered, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_wrreq", fifo_wrreq, 0);
    chk("async_rst_state", state, ST_IDLE);
    fifo_wrempty = 1'b0;
    trig_slope   = TRIG_RISING;
    trig_level   = 8'd128;
    #2;
    reset = 1'b1;
    base = wr_cnt;
    drive(8'd100, 1'b1);
    drive(8'd140, 1'b1);
    drive(8'd100, 1'b1);
    chk("partial_wait_empty", state, ST_WAIT_EMPTY);
    chk("partial_no_writes", wr_cnt - base, 0);
    fifo_wrempty = 1'b1;
    tick();
    chk("partial_rearmed", state, ST_ARMED);

    // Rising slope with level 2: lower threshold saturates at 0
    do_reset();
    trig_level = 8'd2;
    go_armed("low_armed");
    base = wr_cnt;
    for (int r = 0; r < 12; r++)
      for (int j = 0; j < 6; j++) drive(low[j], 1'b1);
    chk("low_no_writes", wr_cnt - base, 0);
    chk("low_still_armed", state, ST_ARMED);

    // Trigger coincides with a full FIFO
    do_reset();
    go_armed("tf_armed");
    base = wr_cnt;
    drive(8'd100, 1'b1);
    fifo_wrfull  = 1'b1;
    fifo_wrempty = 1'b0;
    drive(8'd140, 1'b1);
    chk("tf_capture", state, ST_CAPTURE);
    chk("tf_wrreq", fifo_wrreq, 0);
    tick();
    chk("tf_holdoff", state, ST_HOLDOFF);
    chk("tf_no_words", wr_cnt - base, 0);
    fifo_wrfull  = 1'b0;
    fifo_wrempty = 1'b1;

    // Constant 50 against level 128: only the auto trigger can fire
    do_reset();
    go_armed("auto_armed");
    base = wr_cnt;
    sample_in    = 8'd50;
    sample_valid = 1'b1;
`ifdef CAPTURE_TRIG_AUTO_EN
    armed = 0;
    k = 0;
    while (trig_auto !== 1'b1 && k < 500) begin
      if (state == ST_ARMED) armed++;
      tick();
      k++;
    end
    // 100 full ARMED clocks elapse, the forced trigger lands on the 101st
    chk("auto_armed_clocks", armed, AUTO_N + 1);
    chk("auto_pulse", trig_auto, 1);
    chk("auto_wrreq", fifo_wrreq, 1);
    chk("auto_word", fifo_data, 50);
    tick();
    chk("auto_pulse_end", trig_auto, 0);
    chk("auto_capture", state, ST_CAPTURE);
`else
    armed = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (trig_auto !== 1'b0) armed++;
    end
    chk("noauto_no_writes", wr_cnt - base, 0);
    chk("noauto_trig_auto", armed, 0);
    chk("noauto_armed", state, ST_ARMED);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/capture_trigger_ctrl.md
# capture_trigger_ctrl

Oscilloscope-style trigger and capture sequencer sitting in the ADC clock domain in front of the sample FIFO. It watches the 8-bit down-scaled ADC stream, waits for the FIFO to drain, arms on a level/slope trigger, then writes exactly one FIFO-full frame starting at the trigger sample. After the frame it holds off before re-arming. The display side drains the FIFO unchanged.

## Interface
- DATA_W, 8, sample width
- HYST, 4, trigger hysteresis in LSBs
- HOLDOFF, 64, valid samples ignored after a frame completes
- AUTO_TIMEOUT, 1000000, clocks in ARMED before a forced trigger
- clk  in  1  ADC sample clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- sample_in  in  DATA_W  down-scaled ADC sample
- sample_valid  in  1  sample_in is valid this cycle
- trig_level  in  DATA_W  trigger threshold, quasi-static
- trig_slope  in  1  0 = rising, 1 = falling
- single_shot  in  1  1 = one frame per arm pulse; 0 = continuous
- arm  in  1  one-cycle request to start a capture
- fifo_wrfull  in  1  FIFO write-side full flag
- fifo_wrempty  in  1  FIFO write-side empty flag
- fifo_data  out  DATA_W  registered sample to FIFO
- fifo_wrreq  out  1  FIFO write request
- triggered  out  1  high from trigger through end of CAPTURE
- trig_auto  out  1  one-cycle pulse on forced trigger
- state  out  3  current state encoding for debug

## Operation
- States: IDLE, WAIT_EMPTY, ARMED, CAPTURE, HOLDOFF.
- IDLE -> WAIT_EMPTY on arm = 1, or unconditionally when single_shot = 0. arm in any other state is ignored.
- WAIT_EMPTY: no writes. Goes to ARMED when fifo_wrempty = 1.
- ARMED uses a hysteresis flag that is cleared on entry.
  - Rising slope: flag sets on a valid sample < trig_level − HYST. The subtraction saturates at 0.
  - Falling slope: flag sets on a valid sample > trig_level + HYST. The addition saturates at 2^DATA_W − 1.
  - Trigger fires on a valid sample ≥ trig_level (rising) or ≤ trig_level (falling) while the flag is set.
  - On trigger: go to CAPTURE.
- CAPTURE: every valid sample is written. Goes to HOLDOFF on the first cycle fifo_wrfull = 1.
- HOLDOFF: count HOLDOFF valid samples, then go to IDLE.
- sample_valid = 0: no comparison, no write, holdoff count frozen.

## Timing
- Reset values:
  - state = IDLE
  - fifo_wrreq, triggered, trig_auto = 0
  - fifo_data = 0
  - hysteresis flag and all counters = 0
- fifo_data and the internal write strobe are registered together, giving 1-cycle latency from sample_in.
- The triggering sample is the first word written. It appears on fifo_data, with fifo_wrreq = 1, one clock after it is on sample_in.
- fifo_wrreq = write strobe AND NOT fifo_wrfull, gated combinationally. A write is never presented while full.
- When trigger and fifo_wrfull = 1 occur in the same cycle, the trigger still wins. CAPTURE then exits on the next cycle with zero words written.
- triggered rises with the first fifo_wrreq and falls on entry to HOLDOFF.
- Reset asserted mid-CAPTURE: fifo_wrreq drops asynchronously. The FIFO keeps a partial frame. After reset the block re-enters through WAIT_EMPTY only, so a partial frame is never appended to.
- HOLDOFF = 0: HOLDOFF lasts exactly one clock.

## Configuration
- CAPTURE_TRIG_AUTO_EN defined:
  - A clock counter runs in ARMED and resets on entry to ARMED.
  - When it reaches AUTO_TIMEOUT with no trigger, the block forces a trigger on the next valid sample, ignoring the hysteresis flag.
  - trig_auto pulses for one clock with that trigger.
- Not defined: ARMED waits indefinitely, trig_auto is tied 0, and the counter is not synthesized.

## Structure
- Shared package (capture_pkg) holds:
  - the state encoding
  - the slope constants TRIG_RISING/TRIG_FALLING
  - the default DATA_W
- Sub-module trigger_detect holds the hysteresis flag, the saturating threshold arithmetic and the crossing compare. Interface: sample, valid, level, slope, clear, force → hit.

## Test plan
- Continuous mode, FIFO empty, ramp 0→255 on every clock, trig_level = 128 rising → first written word = 128; triggered rises with it.
- Single-shot, no arm pulse for 1000 clocks → fifo_wrreq stays 0 and state = IDLE; one arm pulse → exactly one frame is written, then the block returns to IDLE.
- Noise hovering at 126–130 with trig_level = 128, HYST = 4 and no excursion below 124 → no trigger. One dip to 120, then 128 → trigger.
- Falling slope, level = 200, samples 255, 190 → trigger on 190. Rising slope, level = 2: the hysteresis threshold saturates at 0, so no sample can set the flag and no trigger fires.
- fifo_wrfull asserts mid-CAPTURE → fifo_wrreq = 0 in that same cycle; state = HOLDOFF next cycle; exactly HOLDOFF valid samples pass before IDLE.
- With CAPTURE_TRIG_AUTO_EN, AUTO_TIMEOUT = 100 and a constant input of 50 against level 128 → trig_auto pulses after 100 ARMED clocks and a frame is captured. Without the macro, nothing is captured for 10000 clocks.
